// File: rtl/dest_ctrl_pkg.sv
// Shared types and opcodes for the line-follower destination sequencer.
package dest_ctrl_pkg;
    typedef enum logic [0:0] {IDLE, GO} state_t;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_GO   = 2'b01;
endpackage

// File: rtl/dest_ctrl_buzz_gen.sv
// Piezo driver: square wave of period 2*BUZZ_HLF while en is high; both outputs low otherwise.
module buzz_gen #(
    parameter int BUZZ_HLF = 12500
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);
    localparam int CW = (BUZZ_HLF > 1) ? $clog2(BUZZ_HLF) : 1;

    logic [CW-1:0] cnt_q;
    logic          ph_q;
    logic          act_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
            act_q <= 1'b0;
        end else if (!en) begin
            cnt_q <= '0;
            ph_q  <= 1'b0;
            act_q <= 1'b0;
        end else begin
            act_q <= 1'b1;
            if (cnt_q == CW'(BUZZ_HLF - 1)) begin
                cnt_q <= '0;
                ph_q  <= ~ph_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    // act_q keeps buzz_n low in the idle state while still giving ~buzz when driving.
    assign buzz   = ph_q;
    assign buzz_n = act_q & ~ph_q;
endmodule

// File: rtl/dest_ctrl.sv
// Motion sequencer: drives the robot to a commanded station ID, with no-barcode timeout.
// Optional obstacle buzzer is built when BUZZ_EN is defined.
module dest_ctrl
    import dest_ctrl_pkg::*;
#(
    parameter int TMO_W    = 26,
    parameter int TMO_CYC  = 50000000,
    parameter int BUZZ_HLF = 12500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_rdy,
    input  logic [7:0] cmd,
    output logic       clr_cmd_rdy,
    input  logic       ID_vld,
    input  logic [7:0] ID,
    output logic       clr_ID_vld,
    input  logic       OK2Move,
    output logic       go,
    output logic       in_transit,
    output logic       arrived,
    output logic       tmo,
    output logic       buzz,
    output logic       buzz_n
);
    state_t             state_q;
    logic [5:0]         dest_q;
    logic [TMO_W-1:0]   tmo_cnt_q;
    logic               in_transit_q;
    logic               arrived_q;
    logic               tmo_q;

    logic [1:0] op;
    assign op = cmd[7:6];

    // Upper ID bits are always zero on a valid barcode.
    logic id_unused;
    assign id_unused = ^ID[7:6];

    // While moving a pending command shadows the ID so it is judged against the new dest.
    always_comb begin
        clr_cmd_rdy = 1'b0;
        clr_ID_vld  = 1'b0;
        if (!rst) begin
            clr_cmd_rdy = cmd_rdy;
            clr_ID_vld  = (state_q == IDLE) ? ID_vld : (ID_vld & ~cmd_rdy);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            dest_q       <= 6'h00;
            tmo_cnt_q    <= '0;
            in_transit_q <= 1'b0;
            arrived_q    <= 1'b0;
            tmo_q        <= 1'b0;
        end else begin
            arrived_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cmd_rdy && op == OP_GO) begin
                        dest_q       <= cmd[5:0];
                        in_transit_q <= 1'b1;
                        tmo_q        <= 1'b0;
                        tmo_cnt_q    <= '0;
                        state_q      <= GO;
                    end
                end
                GO: begin
                    if (cmd_rdy && op == OP_GO) begin
                        dest_q    <= cmd[5:0];
                        tmo_cnt_q <= '0;
                    end else if (cmd_rdy && op == OP_STOP) begin
                        in_transit_q <= 1'b0;
                        state_q      <= IDLE;
                    end else if (ID_vld && !cmd_rdy) begin
                        tmo_cnt_q <= '0;
                        if (ID[5:0] == dest_q) begin
                            in_transit_q <= 1'b0;
                            arrived_q    <= 1'b1;
                            state_q      <= IDLE;
                        end
                    end else if (OK2Move) begin
                        // Count holds at the compare value; leaving GO stops it.
                        if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                            in_transit_q <= 1'b0;
                            tmo_q        <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_transit = in_transit_q;
    assign arrived    = arrived_q;
    assign tmo        = tmo_q;
    assign go         = in_transit_q & OK2Move;

`ifdef BUZZ_EN
    buzz_gen #(.BUZZ_HLF(BUZZ_HLF)) u_buzz (
        .clk    (clk),
        .rst    (rst),
        .en     (in_transit_q & ~OK2Move),
        .buzz   (buzz),
        .buzz_n (buzz_n)
    );
`else
    logic buzz_unused;
    assign buzz_unused = ^BUZZ_HLF;
    assign buzz        = 1'b0;
    assign buzz_n      = 1'b0;
`endif
endmodule
